// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake, hold, flush and bubble insertion.
// Define IF_ID_SKID_EN to add a skid entry so that in_ready comes straight from a flop.
module if_id_pipe_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  pc_plus4_in,
    input  logic [XLEN-1:0]  instr_in,
    input  logic             hold,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4_out,
    output logic [XLEN-1:0]  instr_out,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [XLEN-1:0]  RESET_PC4 = RESET_PC + XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc4_q, pc4_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             in_xfer;
    logic             discard;

`ifdef IF_ID_SKID_EN
    logic             in_ready_q, in_ready_d;
    logic             skid_full_q, skid_full_d;
    logic [XLEN-1:0]  skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]  skid_pc4_q, skid_pc4_d;
    logic [XLEN-1:0]  skid_instr_q, skid_instr_d;

    assign in_ready = in_ready_q;
    assign discard  = out_valid_q | skid_full_q | in_xfer;
`else
    assign in_ready = (~out_valid_q | out_ready) & (flush | ~hold);
    assign discard  = out_valid_q | in_xfer;
`endif

    assign in_xfer = in_valid & in_ready;

    // Next-state: flush > hold > normal.
    always_comb begin
        out_valid_d  = out_valid_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        instr_d      = instr_q;
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
`ifdef IF_ID_SKID_EN
        skid_full_d  = skid_full_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            instr_d     = NOP_INSTR;
`ifdef IF_ID_SKID_EN
            skid_full_d = 1'b0;
`endif
        end else if (hold) begin
`ifdef IF_ID_SKID_EN
            // in_ready is one cycle late, so a transfer on the rising hold edge parks in the skid.
            if (in_xfer) begin
                skid_full_d  = 1'b1;
                skid_pc_d    = pc_in;
                skid_pc4_d   = pc_plus4_in;
                skid_instr_d = instr_in;
            end
`endif
        end else begin
`ifdef IF_ID_SKID_EN
            if (~out_valid_q | out_ready) begin
                if (skid_full_q) begin
                    out_valid_d = 1'b1;
                    pc_d        = skid_pc_q;
                    pc4_d       = skid_pc4_q;
                    instr_d     = skid_instr_q;
                    skid_full_d = 1'b0;
                end else if (in_xfer) begin
                    out_valid_d = 1'b1;
                    pc_d        = pc_in;
                    pc4_d       = pc_plus4_in;
                    instr_d     = instr_in;
                end else begin
                    out_valid_d = 1'b0;
                    instr_d     = NOP_INSTR;
                end
            end else if (in_xfer) begin
                skid_full_d  = 1'b1;
                skid_pc_d    = pc_in;
                skid_pc4_d   = pc_plus4_in;
                skid_instr_d = instr_in;
            end
`else
            if (in_xfer) begin
                out_valid_d = 1'b1;
                pc_d        = pc_in;
                pc4_d       = pc_plus4_in;
                instr_d     = instr_in;
            end else if (out_valid_q & out_ready) begin
                out_valid_d = 1'b0;
                instr_d     = NOP_INSTR;
            end
`endif
        end

        if (!hold && flush && discard && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (!hold && out_ready && !out_valid_q && bubble_cnt_q != CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
`ifdef IF_ID_SKID_EN
        in_ready_d = (hold & ~flush) ? 1'b0 : ~skid_full_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            pc_q         <= RESET_PC;
            pc4_q        <= RESET_PC4;
            instr_q      <= NOP_INSTR;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            instr_q      <= instr_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q   <= 1'b1;
            skid_full_q  <= 1'b0;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_instr_q <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            skid_full_q  <= skid_full_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
        end
    end
`endif

    assign out_valid    = out_valid_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc4_q;
    assign instr_out    = instr_q;
    assign flush_cnt    = flush_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench for if_id_pipe_stage; a second CNT_W=2 instance shares the stimulus for saturation.
module tb_if_id_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, hold, flush, out_ready;
    logic [31:0] pc_in, pc_plus4_in, instr_in;

    logic        in_ready, out_valid;
    logic [31:0] pc_out, pc_plus4_out, instr_out;
    logic [15:0] flush_cnt, bubble_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_pc_out, s_pc_plus4_out, s_instr_out;
    logic [1:0]  s_flush_cnt, s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    if_id_pipe_stage #(.XLEN(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .pc_plus4_in(pc_plus4_in), .instr_in(instr_in),
        .hold(hold), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .instr_out(instr_out),
        .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
    );

    if_id_pipe_stage #(.XLEN(32), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .pc_in(pc_in), .pc_plus4_in(pc_plus4_in), .instr_in(instr_in),
        .hold(hold), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .pc_out(s_pc_out), .pc_plus4_out(s_pc_plus4_out), .instr_out(s_instr_out),
        .flush_cnt(s_flush_cnt), .bubble_cnt(s_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid    = v;
        pc_in       = pc;
        pc_plus4_in = pc + 32'd4;
        instr_in    = 32'hA000_0000 | pc;
    endtask

    task automatic chk_entry(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
        chk({tag, "_valid"}, 64'(out_valid), 64'(v));
        chk({tag, "_pc"},    64'(pc_out), 64'(pc));
        chk({tag, "_pc4"},   64'(pc_plus4_out), 64'(pc + 32'd4));
        chk({tag, "_instr"}, 64'(instr_out), 64'(instr));
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0);
        step(); step();
        chk_entry("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fcnt", 64'(flush_cnt), 64'd0);
        chk("rst_bcnt", 64'(bubble_cnt), 64'd0);
        reset = 1'b1;
        step();

        // Stream: one entry per cycle, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'h100);
        chk("str_rdy0", 64'(in_ready), 64'd1);
        step();
        chk_entry("str0", 1'b1, 32'h100, 32'hA000_0100);
        drive(1'b1, 32'h104);
        chk("str_rdy1", 64'(in_ready), 64'd1);
        step();
        chk_entry("str1", 1'b1, 32'h104, 32'hA000_0104);
        drive(1'b1, 32'h108);
        chk("str_rdy2", 64'(in_ready), 64'd1);
        step();
        chk_entry("str2", 1'b1, 32'h108, 32'hA000_0108);
        drive(1'b0, 32'h0);
        step();
        chk_entry("drain", 1'b0, 32'h108, 32'h0);
        chk("str_bcnt", 64'(bubble_cnt), 64'd1);

        // Stall with 0x200 on the outputs
        out_ready = 1'b0;
        drive(1'b1, 32'h200);
        step();
        chk_entry("stl0", 1'b1, 32'h200, 32'hA000_0200);
        drive(1'b1, 32'h204);
`ifdef IF_ID_SKID_EN
        chk("stl_rdy_skid", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 32'h0);
        chk("stl_rdy_full", 64'(in_ready), 64'd0);
`else
        chk("stl_rdy", 64'(in_ready), 64'd0);
        step();
`endif
        chk_entry("stl1", 1'b1, 32'h200, 32'hA000_0200);
        step();
        chk_entry("stl2", 1'b1, 32'h200, 32'hA000_0200);
        out_ready = 1'b1;
        step();
        chk_entry("stl3", 1'b1, 32'h204, 32'hA000_0204);
        drive(1'b0, 32'h0);
        step();
        chk_entry("stl_drain", 1'b0, 32'h204, 32'h0);
        chk("stl_bcnt", 64'(bubble_cnt), 64'd1);

        // Flush with a valid entry and an incoming 0x300
        out_ready = 1'b0;
        drive(1'b1, 32'h2F0);
        step();
        chk_entry("fl_pre", 1'b1, 32'h2F0, 32'hA000_02F0);
        drive(1'b1, 32'h300);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk_entry("fl", 1'b0, 32'h2F0, 32'h0);
        chk("fl_cnt", 64'(flush_cnt), 64'd1);
        step();
        chk_entry("fl_post", 1'b0, 32'h2F0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_empty_cnt", 64'(flush_cnt), 64'd1);

        // Hold for 3 cycles with in_valid=1 and out_ready=1
        drive(1'b1, 32'h400);
        step();
        chk_entry("hd_pre", 1'b1, 32'h400, 32'hA000_0400);
        hold = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h404);
`ifdef IF_ID_SKID_EN
        chk("hd_rdy_rise", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 32'h0);
`else
        chk("hd_rdy_rise", 64'(in_ready), 64'd0);
        step();
`endif
        chk_entry("hd1", 1'b1, 32'h400, 32'hA000_0400);
        step();
        chk("hd_rdy", 64'(in_ready), 64'd0);
        chk_entry("hd2", 1'b1, 32'h400, 32'hA000_0400);
        step();
        chk_entry("hd3", 1'b1, 32'h400, 32'hA000_0400);
        hold = 1'b0;
        drive(1'b0, 32'h0);
`ifdef IF_ID_SKID_EN
        step();
        chk_entry("hd_skid_out", 1'b1, 32'h404, 32'hA000_0404);
        step();
        chk_entry("hd_rel", 1'b0, 32'h404, 32'h0);
`else
        step();
        chk_entry("hd_rel", 1'b0, 32'h400, 32'h0);
`endif
        chk("hd_bcnt", 64'(bubble_cnt), 64'd1);

        // Hold on an empty stage must not count bubbles
        hold = 1'b1;
        step(); step();
        chk("hde_bcnt", 64'(bubble_cnt), 64'd1);
        hold = 1'b0;

        // Five bubble cycles: wide counter reaches 6, 2-bit counter saturates at 3
        step(); step();
        chk("bub_mid", 64'(bubble_cnt), 64'd3);
        chk("bub_mid_sat", 64'(s_bubble_cnt), 64'd3);
        step(); step(); step();
        chk("bub_cnt", 64'(bubble_cnt), 64'd6);
        chk("bub_sat", 64'(s_bubble_cnt), 64'd3);
        chk("fl_sat", 64'(s_flush_cnt), 64'd1);
        chk("sat_valid", 64'(s_out_valid), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, 32'h500);
        step();
        drive(1'b0, 32'h0);
        chk_entry("ar_pre", 1'b1, 32'h500, 32'hA000_0500);
        #2;
        reset = 1'b0;
        #1;
        chk_entry("ar", 1'b0, 32'h0, 32'h0);
        chk("ar_fcnt", 64'(flush_cnt), 64'd0);
        chk("ar_bcnt", 64'(bubble_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
